sensor_scan_ctrl: RTL

SENSOR_SCAN_CTRL -- requirements
Module: sensor_scan_ctrl

---
 rtl/sensor_scan_ctrl_pkg.sv | 27 ++
 rtl/sensor_scan_ctrl_col_first_hit.sv | 32 +++
 rtl/sensor_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sensor_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sensor_scan_ctrl_pkg
// Shared definitions for the sensor-matrix scan blocks: matrix geometry, the
// scan-state encoding and a row one-hot helper.
// -----------------------------------------------------------------------------
package sensor_scan_ctrl_pkg;

    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 5;

    // Two bits cover all four states, so every encoding has a defined meaning.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_REPORT = 2'd3
    } scan_state_e;

    // One-hot row drive pattern for a row index (bit0 = bottom row).
    function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [2:0] row);
        logic [NUM_ROWS-1:0] v;
        v      = {NUM_ROWS{1'b0}};
        v[row] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sensor_scan_ctrl_col_first_hit.sv
// -----------------------------------------------------------------------------
// col_first_hit
// Combinational priority encoder: reports the index of the lowest set bit of
// the column sense vector (bit0 = right-most column) and whether any bit is set.
// Ports:
//   col  in   NUM_COLS  column hits for the currently driven row
//   idx  out  4         index of the lowest set bit, 0 when no hit
//   hit  out  1         at least one column bit is set
// -----------------------------------------------------------------------------
module col_first_hit
    import sensor_scan_ctrl_pkg::*;
(
    input  logic [NUM_COLS-1:0] col,
    output logic [3:0]          idx,
    output logic                hit
);

    // Lowest set bit wins so the reported column is deterministic.
    always_comb begin
        idx = 4'd0;
        hit = 1'b0;
        casez (col)
            5'b????1: begin idx = 4'd0; hit = 1'b1; end
            5'b???10: begin idx = 4'd1; hit = 1'b1; end
            5'b??100: begin idx = 4'd2; hit = 1'b1; end
            5'b?1000: begin idx = 4'd3; hit = 1'b1; end
            5'b10000: begin idx = 4'd4; hit = 1'b1; end
            default:  begin idx = 4'd0; hit = 1'b0; end
        endcase
    end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sensor_scan_ctrl
// Scans an 8x5 sensor matrix one row at a time, lets each row settle for
// SETTLE_TICKS scan ticks, samples it once, and publishes the first hit of
// each frame as a debounced ball position.
// Ports:
//   clk           in   1         system clock, rising edge
//   rst_n         in   1         asynchronous active-low reset
//   clk_en        in   1         scan tick; scanning advances only when high
//   col_in        in   5         column hits of the driven row (bit0 = right)
//   row_sel       out  8         one-hot row drive (bit0 = bottom)
//   ball_detected out  1         ball present, cleared after MISS_FRAMES empty frames
//   x_pos_calc    out  4         row of the published hit
//   y_pos_calc    out  4         column of the published hit
//   frame_valid   out  1         one-clk pulse coinciding with freshly published results
// -----------------------------------------------------------------------------
module sensor_scan_ctrl
    import sensor_scan_ctrl_pkg::*;
#(
    parameter int SETTLE_TICKS = 2,
    parameter int MISS_FRAMES  = 3
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_sel,
    output logic                ball_detected,
    output logic [3:0]          x_pos_calc,
    output logic [3:0]          y_pos_calc,
    output logic                frame_valid
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_TICKS - 1);
    localparam logic [3:0] MISS_LIMIT  = 4'(MISS_FRAMES);
    localparam logic [2:0] LAST_ROW    = 3'(NUM_ROWS - 1);

    scan_state_e         state_r;
    logic [2:0]          row_r;
    logic [3:0]          settle_r;
    logic [3:0]          miss_r;
    logic                hit_flag_r;
    logic [2:0]          frame_x_r;
    logic [3:0]          frame_y_r;
    logic [NUM_ROWS-1:0] row_sel_r;
    logic                ball_r;
    logic [3:0]          x_pos_r;
    logic [3:0]          y_pos_r;
    logic                frame_valid_r;

    logic [3:0]          hit_idx_s;
    logic                hit_s;

    col_first_hit u_col_first_hit (
        .col (col_in),
        .idx (hit_idx_s),
        .hit (hit_s)
    );

    // Scan FSM, frame accumulation and registered result outputs.
    // row_sel is computed together with the next state so it is a clean flop
    // output. frame_valid rises on the edge that ends REPORT, together with the
    // updated position/ball outputs, so a consumer sees a coherent result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            row_r         <= 3'd0;
            settle_r      <= 4'd0;
            miss_r        <= 4'd0;
            hit_flag_r    <= 1'b0;
            frame_x_r     <= 3'd0;
            frame_y_r     <= 4'd0;
            row_sel_r     <= {NUM_ROWS{1'b0}};
            ball_r        <= 1'b0;
            x_pos_r       <= 4'd0;
            y_pos_r       <= 4'd0;
            frame_valid_r <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (clk_en) begin
                        state_r    <= ST_SETTLE;
                        row_r      <= 3'd0;
                        settle_r   <= 4'd0;
                        hit_flag_r <= 1'b0;
                        row_sel_r  <= row_onehot(3'd0);
                    end
                end
                ST_SETTLE: begin
                    // The row dwells SETTLE_TICKS ticks here before its sample tick.
                    if (clk_en) begin
                        if (settle_r == SETTLE_LAST) begin
                            state_r <= ST_SAMPLE;
                        end else begin
                            settle_r <= settle_r + 4'd1;
                        end
                    end
                end
                ST_SAMPLE: begin
                    if (clk_en) begin
                        // Only the first hit of a frame is kept.
                        if (hit_s && !hit_flag_r) begin
                            frame_x_r  <= row_r;
                            frame_y_r  <= hit_idx_s;
                            hit_flag_r <= 1'b1;
                        end
                        if (row_r == LAST_ROW) begin
                            state_r   <= ST_REPORT;
                            row_sel_r <= {NUM_ROWS{1'b0}};
                        end else begin
                            state_r   <= ST_SETTLE;
                            row_r     <= row_r + 3'd1;
                            settle_r  <= 4'd0;
                            row_sel_r <= row_onehot(row_r + 3'd1);
                        end
                    end
                end
                ST_REPORT: begin
                    // Single clk regardless of clk_en, then restart at row 0.
                    frame_valid_r <= 1'b1;
                    if (hit_flag_r) begin
                        x_pos_r <= {1'b0, frame_x_r};
                        y_pos_r <= frame_y_r;
                        ball_r  <= 1'b1;
                        miss_r  <= 4'd0;
                    end else if (miss_r < MISS_LIMIT) begin
                        miss_r <= miss_r + 4'd1;
                        if ((miss_r + 4'd1) >= MISS_LIMIT) begin
                            ball_r <= 1'b0;
                        end
                    end else begin
                        ball_r <= 1'b0;
                    end
                    state_r    <= ST_SETTLE;
                    row_r      <= 3'd0;
                    settle_r   <= 4'd0;
                    hit_flag_r <= 1'b0;
                    row_sel_r  <= row_onehot(3'd0);
                end
                default: begin
                    state_r   <= ST_IDLE;
                    row_sel_r <= {NUM_ROWS{1'b0}};
                end
            endcase
        end
    end

    assign row_sel       = row_sel_r;
    assign ball_detected = ball_r;
    assign x_pos_calc    = x_pos_r;
    assign y_pos_calc    = y_pos_r;
    assign frame_valid   = frame_valid_r;

endmodule
